shared_mem_port: RTL and testbench
==================================

# shared_mem_port

Posted-write port between one RISC-V core's data-memory bus and the row-shared URAM. It buffers core stores to the shared region in a small FIFO and requests the row arbiter. Once granted, it drains one entry per cycle onto a URAM port that may be wider than the core word. It bounds each burst so the row stays fair, and replaces the grant-gated, full-word-only, combinational URAM path with byte-enabled, lane-packed, arbitrated writes.

## Interface
Parameters:
- ADDR_WIDTH, 12: core word-address width into the shared region.
- URAM_DATA_WIDTH, 64: URAM port width; 32, 64 or 128.
- FIFO_DEPTH, 4: posted-write entries; power of two, ≥2.
- MAX_BURST, 8: maximum pops per grant before a forced release; ≥1.

Ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset (asserted when 0).
- i_wr_valid, in, 1: core store to the shared region this cycle.
- i_wr_addr, in, ADDR_WIDTH: core word address.
- i_wr_data, in, 32: store data.
- i_wr_be, in, 4: byte enables.
- i_clear_overflow, in, 1: clears o_overflow (MMIO write).
- o_fifo_empty, out, 1: FIFO holds no entries (MMIO-readable; software polls it before barriers).
- o_fifo_full, out, 1: count == FIFO_DEPTH.
- o_overflow, out, 1: sticky flag; a store was dropped.
- o_core_req, out, 1: request to the row arbiter.
- i_core_grant, in, 1: grant from the row arbiter.
- o_uram_en, out, 1: URAM access strobe.
- o_uram_addr, out, ADDR_WIDTH-LANE_BITS: URAM row address.
- o_uram_wr_data, out, URAM_DATA_WIDTH: write data.
- o_uram_be, out, URAM_DATA_WIDTH/8: byte write enables.

## Operation
- Derived constants: LANES = URAM_DATA_WIDTH/32 and LANE_BITS = log2(LANES); LANE_BITS is 0 when LANES = 1.
- Push: an entry {addr, data, be} is accepted when i_wr_valid=1 and either count<FIFO_DEPTH or a pop occurs in the same cycle.
- Drop: i_wr_valid=1 while full with no pop drops the store and sets o_overflow.
- o_overflow: cleared by i_clear_overflow. If set and clear coincide, set wins.
- Lane mapping: lane = addr[LANE_BITS-1:0] and o_uram_addr = addr >> LANE_BITS. o_uram_wr_data replicates the data across all lanes. o_uram_be = be << (4·lane), so only the addressed lane's bytes are written.
- A store with be=0 is still queued and issued as a no-op write.
- FSM states:
  - IDLE: o_core_req=0. Moves to REQ when the FIFO is non-empty.
  - REQ: o_core_req=1. Moves to DRAIN on i_core_grant=1; the burst counter is cleared on entry.
  - DRAIN: o_core_req=1. In every cycle with i_core_grant=1, the FIFO head is presented on the URAM port and popped at the clock edge, and the burst counter increments. Exits on the first of:
    - i_core_grant=0: to REQ, with no pop that cycle.
    - FIFO empty after the pop: to RELEASE.
    - Burst counter reaches MAX_BURST: to RELEASE.
  - RELEASE: o_core_req=0 for exactly one cycle, then IDLE.
- URAM outputs are combinational: head entry gated by (state==DRAIN && i_core_grant). When not gated, o_uram_en, o_uram_addr, o_uram_wr_data and o_uram_be are all 0.
- Order: entries are issued strictly in push order and never merged.

## Timing
- Reset state: FIFO empty, state IDLE, burst counter 0. Outputs: o_fifo_empty=1; o_fifo_full, o_overflow, o_core_req and all URAM outputs 0.
- Latency: a push at edge t is counted after t. FSM enters REQ at t+1, so o_core_req=1 after t+1. With grant already high, DRAIN is entered at t+2 and the URAM write is presented in cycle t+2 and popped at edge t+3. Minimum push-to-URAM is 2 cycles.
- Throughput: one URAM write per granted DRAIN cycle. Simultaneous push and pop when full keeps count at FIFO_DEPTH and sets no overflow.
- Grant loss: if grant drops in DRAIN, the head entry is retained, no write is issued that cycle, and the request stays asserted.
- Burst release: after a forced release with entries remaining, req drops for one RELEASE cycle plus one IDLE cycle, then re-asserts.
- Reset mid-drain: all outputs go to 0 immediately on assertion. Queued entries are discarded.

## Structure
- riscv_pkg: shm_port_state_e (IDLE, REQ, DRAIN, RELEASE) and the shm_wr_entry_t struct {addr, data[31:0], be[3:0]}.
- Sub-module shm_wr_fifo: synchronous FIFO, parametrised by entry type and depth. Provides count, full/empty, and simultaneous push/pop.
- FSM, burst counter and lane mapping live in shared_mem_port.

## Test plan
- Single store, grant already high, URAM_DATA_WIDTH=64: addr=0x005, data=0xDEADBEEF, be=0xF → cycle t+2 shows o_uram_addr=0x002, o_uram_be=0xF0, data=0xDEADBEEF_DEADBEEF. Then one RELEASE cycle with req=0, and o_fifo_empty=1.
- Fill to 4 with grant low, then push a 5th → o_fifo_full=1, o_overflow=1, 5th entry absent. Next: raise grant → 4 writes in order. Finally: pulse i_clear_overflow → o_overflow=0.
- MAX_BURST=2, 4 queued, grant held high → 2 writes, req=0 for 2 cycles, 2 more writes.
- Drop grant during DRAIN after the first pop → no URAM strobe while grant is low; the second entry is issued unchanged after re-grant.
- URAM_DATA_WIDTH=32: addr=0xFFF, be=0x3 → o_uram_addr=0xFFF, o_uram_be=0x3.
- Assert reset with 3 entries mid-drain → outputs 0 immediately. After release: o_fifo_empty=1, req stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the core-to-URAM posted-write port: FSM states, the
// queued write entry and the lane byte-enable helper.
package riscv_pkg;

    // Widest core word address an entry can carry; ports narrow it.
    localparam int SHM_ADDR_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RELEASE = 2'd3
    } shm_port_state_e;

    typedef struct packed {
        logic [SHM_ADDR_MAX-1:0] addr;
        logic [31:0]             data;
        logic [3:0]              be;
    } shm_wr_entry_t;

    // Move a 4-bit word byte-enable into its lane of a 16-byte (max) row.
    function automatic logic [15:0] lane_be(input logic [3:0] be, input logic [1:0] lane);
        return 16'(be) << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/shm_wr_fifo.sv
// Synchronous FIFO for posted writes: head is visible combinationally,
// and a push into a full FIFO is legal when a pop happens in the same cycle.
module shm_wr_fifo #(
    parameter type T         = logic [7:0],
    parameter int  DEPTH     = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  T                 wdata_i,
    input  logic             pop_i,
    output T                 rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Next pointers and occupancy from the qualified push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/shared_mem_port.sv
// Posted-write port from a core data bus into the row-shared URAM: queues
// stores, requests the row arbiter, and drains one lane-packed write per
// granted cycle with a bounded burst length so the row stays fair.
module shared_mem_port
    import riscv_pkg::*;
#(
    parameter int  ADDR_WIDTH      = 12,
    parameter int  URAM_DATA_WIDTH = 64,
    parameter int  FIFO_DEPTH      = 4,
    parameter int  MAX_BURST       = 8,
    localparam int LANES           = URAM_DATA_WIDTH / 32,
    localparam int LANE_BITS       = (LANES > 1) ? $clog2(LANES) : 0,
    localparam int BE_W            = URAM_DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_wr_valid,
    input  logic [ADDR_WIDTH-1:0]           i_wr_addr,
    input  logic [31:0]                     i_wr_data,
    input  logic [3:0]                      i_wr_be,
    input  logic                            i_clear_overflow,
    output logic                            o_fifo_empty,
    output logic                            o_fifo_full,
    output logic                            o_overflow,
    output logic                            o_core_req,
    input  logic                            i_core_grant,
    output logic                            o_uram_en,
    output logic [ADDR_WIDTH-LANE_BITS-1:0] o_uram_addr,
    output logic [URAM_DATA_WIDTH-1:0]      o_uram_wr_data,
    output logic [BE_W-1:0]                 o_uram_be
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    shm_port_state_e       state_q, state_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic                  overflow_q, overflow_d;

    shm_wr_entry_t         wr_entry_s;
    shm_wr_entry_t         head_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  gate_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic                  empty_after_pop_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [1:0]            lane_s;
    logic                  unused_addr_s;

    assign wr_entry_s = '{addr: SHM_ADDR_MAX'(i_wr_addr), data: i_wr_data, be: i_wr_be};

    assign gate_s = (state_q == ST_DRAIN) && i_core_grant;
    assign pop_s  = gate_s && !fifo_empty_s;
    assign push_s = i_wr_valid && (!fifo_full_s || pop_s);
    assign drop_s = i_wr_valid && fifo_full_s && !pop_s;
    assign empty_after_pop_s = (fifo_count_s == CNT_W'(1)) && !push_s;

    assign head_addr_s   = head_s.addr[ADDR_WIDTH-1:0];
    assign lane_s        = 2'(head_addr_s & ADDR_WIDTH'(LANES - 1));
    assign unused_addr_s = ^(head_s.addr >> ADDR_WIDTH);

    shm_wr_fifo #(
        .T     (shm_wr_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .wdata_i (wr_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign o_fifo_empty = fifo_empty_s;
    assign o_fifo_full  = fifo_full_s;
    assign o_overflow   = overflow_q;
    assign o_core_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);

    // Arbiter handshake FSM and burst counter: the count restarts on every
    // REQ->DRAIN entry and forces a release once MAX_BURST pops have gone out.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_core_grant) begin
                    state_d = ST_DRAIN;
                    burst_d = '0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (!i_core_grant) begin
                    state_d = ST_REQ;
                end else begin
                    burst_d = burst_q + BURST_W'(1);
                    if (empty_after_pop_s) begin
                        state_d = ST_RELEASE;
                    end else if (burst_q == BURST_W'(MAX_BURST - 1)) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky drop flag; a new drop outranks a same-cycle software clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (i_clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, burst and overflow registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            overflow_q <= overflow_d;
        end
    end

    // URAM port: head entry lane-packed while granted in DRAIN, all zero otherwise.
    always_comb begin
        o_uram_en      = 1'b0;
        o_uram_addr    = '0;
        o_uram_wr_data = '0;
        o_uram_be      = '0;
        if (pop_s) begin
            o_uram_en      = 1'b1;
            o_uram_addr    = head_addr_s[ADDR_WIDTH-1:LANE_BITS];
            o_uram_wr_data = {LANES{head_s.data}};
            o_uram_be      = BE_W'(lane_be(head_s.be, lane_s));
        end else begin
            o_uram_en      = 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_mem_port.sv
// Bench for shared_mem_port: directed scenarios plus a randomized phase,
// with a queue-based reference model of the posted-write buffer.
module tb_shared_mem_port;

    localparam int TB_DEPTH = 4;
    localparam int TB_MAXB  = 2;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic [11:0] wr_addr = 12'h000;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  wr_be = 4'h0;
    logic        clear_ovf = 1'b0;
    logic        core_grant = 1'b0;
    logic        fifo_empty, fifo_full, overflow, core_req, uram_en;
    logic [10:0] uram_addr;
    logic [63:0] uram_wr_data;
    logic [7:0]  uram_be;

    logic        w_valid = 1'b0;
    logic [11:0] w_addr = 12'h000;
    logic [31:0] w_data = 32'h0;
    logic [3:0]  w_be = 4'h0;
    logic        w_grant = 1'b0;
    logic        w_empty, w_full, w_ovf, w_req, w_en;
    logic [11:0] w_uaddr;
    logic [31:0] w_udata;
    logic [3:0]  w_ube;

    int   nvec = 0;
    int   nmis = 0;
    int   run = 0;
    logic m_ovf = 1'b0;
    ent_t mq[$];

    always #5 clk = ~clk;

    shared_mem_port #(.ADDR_WIDTH(12), .URAM_DATA_WIDTH(64), .FIFO_DEPTH(TB_DEPTH), .MAX_BURST(TB_MAXB)) u_dut (
        .clk(clk), .reset(reset), .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_wr_be(wr_be), .i_clear_overflow(clear_ovf), .o_fifo_empty(fifo_empty), .o_fifo_full(fifo_full),
        .o_overflow(overflow), .o_core_req(core_req), .i_core_grant(core_grant), .o_uram_en(uram_en),
        .o_uram_addr(uram_addr), .o_uram_wr_data(uram_wr_data), .o_uram_be(uram_be));

    shared_mem_port #(.ADDR_WIDTH(12), .URAM_DATA_WIDTH(32), .FIFO_DEPTH(4), .MAX_BURST(8)) u_dut32 (
        .clk(clk), .reset(reset), .i_wr_valid(w_valid), .i_wr_addr(w_addr), .i_wr_data(w_data),
        .i_wr_be(w_be), .i_clear_overflow(1'b0), .o_fifo_empty(w_empty), .o_fifo_full(w_full),
        .o_overflow(w_ovf), .o_core_req(w_req), .i_core_grant(w_grant), .o_uram_en(w_en),
        .o_uram_addr(w_uaddr), .o_uram_wr_data(w_udata), .o_uram_be(w_ube));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, then advance the model.
    task automatic tick(input logic v, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic g, input logic clr);
        int   sz0;
        logic popped;
        logic dropped;
        ent_t e;
        @(negedge clk);
        wr_valid = v; wr_addr = a; wr_data = d; wr_be = b; core_grant = g; clear_ovf = clr;
        #1;
        sz0 = mq.size();
        popped = 1'b0;
        dropped = 1'b0;
        chk("empty", fifo_empty, sz0 == 0);
        chk("full", fifo_full, sz0 == TB_DEPTH);
        chk("overflow", overflow, m_ovf);
        if (uram_en === 1'b1) begin
            run++;
            chk("wr_needs_grant", core_grant, 1'b1);
            chk("wr_needs_req", core_req, 1'b1);
            chk("burst_len", run <= TB_MAXB, 1'b1);
            chk("wr_with_entry", sz0 != 0, 1'b1);
            if (sz0 != 0) begin
                e = mq.pop_front();
                popped = 1'b1;
                chk("wr_addr", uram_addr, e.a / 2);
                chk("wr_data", uram_wr_data, {e.d, e.d});
                chk("wr_be", uram_be, 8'(e.b) << (4 * (e.a % 2)));
            end
        end else begin
            run = 0;
            chk("idle_bus", {uram_en, uram_addr, uram_wr_data, uram_be}, '0);
        end
        if (v) begin
            if (sz0 < TB_DEPTH || popped) mq.push_back('{a, d, b});
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] bexp_req;
        logic [8:0] bexp_en;
        logic [7:0] gvec;
        logic [7:0] gexp_req;
        logic [7:0] gexp_en;
        int         nwr;
        logic       g;

        // Reset state
        #23;
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_outs", {fifo_full, overflow, core_req, uram_en, uram_addr, uram_wr_data, uram_be}, '0);
        @(negedge clk);
        reset = 1'b1;

        // Single store, grant already high: written in the third cycle after the push
        tick(1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
        chk("s1_req_t", core_req, 1'b0);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("s1_req_t1", core_req, 1'b0);
        chk("s1_en_t1", uram_en, 1'b0);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("s1_req_t2", core_req, 1'b1);
        chk("s1_en_t2", uram_en, 1'b0);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("s1_en", uram_en, 1'b1);
        chk("s1_addr", uram_addr, 11'h002);
        chk("s1_be", uram_be, 8'hF0);
        chk("s1_data", uram_wr_data, 64'hDEADBEEF_DEADBEEF);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("s1_release_req", core_req, 1'b0);
        chk("s1_release_empty", fifo_empty, 1'b1);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("s1_idle_req", core_req, 1'b0);

        // Fill with grant low, drop a fifth store while clear is pulsed (set wins)
        for (int i = 0; i < 4; i++) tick(1'b1, 12'(16 + i), $urandom, 4'(i + 1), 1'b0, 1'b0);
        tick(1'b1, 12'h0AA, 32'h5555AAAA, 4'hF, 1'b0, 1'b1);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_full", fifo_full, 1'b1);
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
            if (uram_en === 1'b1) nwr++;
        end
        chk("ovf_drain_count", nwr, 4);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b1);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("ovf_cleared", overflow, 1'b0);

        // Burst limit: 4 queued, grant held, 2 writes / 2 low-req cycles / 2 writes
        for (int i = 0; i < 4; i++) tick(1'b1, 12'(32 + i), $urandom, 4'hF, 1'b0, 1'b0);
        bexp_req = 9'b011100111;
        bexp_en  = 9'b011000110;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
            chk("burst_req", core_req, bexp_req[i]);
            chk("burst_en", uram_en, bexp_en[i]);
        end

        // Grant loss mid-drain: head retained, no strobe while grant low
        for (int i = 0; i < 3; i++) tick(1'b1, 12'(64 + i), $urandom, 4'(3 << i), 1'b0, 1'b0);
        gvec     = 8'b11110011;
        gexp_req = 8'b01111111;
        gexp_en  = 8'b01100010;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 12'h000, 32'h0, 4'h0, gvec[i], 1'b0);
            chk("gloss_req", core_req, gexp_req[i]);
            chk("gloss_en", uram_en, gexp_en[i]);
        end

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) tick(1'b1, 12'(80 + i), $urandom, 4'hF, 1'b0, 1'b0);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("mid_drain_en", uram_en, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_now_empty", fifo_empty, 1'b1);
        chk("rst_now_outs", {fifo_full, overflow, core_req, uram_en, uram_addr, uram_wr_data, uram_be}, '0);
        mq.delete();
        m_ovf = 1'b0;
        run = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
            chk("post_rst_req", core_req, 1'b0);
        end

        // Randomized traffic with bursty grant
        g = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) g = ~g;
            tick(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), $urandom,
                 4'($urandom_range(0, 15)), g, 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 40; i++) tick(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("rand_drained", fifo_empty, 1'b1);
        chk("rand_model_empty", mq.size(), 0);

        // 32-bit URAM: one lane, address passes through unchanged
        @(negedge clk);
        w_grant = 1'b1; w_valid = 1'b1; w_addr = 12'hFFF; w_data = 32'hCAFEF00D; w_be = 4'h3;
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        chk("w32_en_t1", w_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("w32_en", w_en, 1'b1);
        chk("w32_addr", w_uaddr, 12'hFFF);
        chk("w32_be", w_ube, 4'h3);
        chk("w32_data", w_udata, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("w32_empty", w_empty, 1'b1);
        chk("w32_release_req", w_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
